// File: rtl/uart_hex_cmd_parser.sv
// uart_hex_cmd_parser
//
// Sits between the UART receiver and the seven-segment driver. It collects
// ASCII hex digits into a right-aligned binary value and commits that value
// on CR or LF.
//
// Editing and recovery:
//   - BS removes the last digit.
//   - ESC abandons the entry.
//   - A bad byte or an overflow drops into ERROR. ERROR swallows bytes until
//     CR, LF or ESC arrives.
//   - A partial entry left idle for TIMEOUT_CYCLES clocks is discarded.
//
// Every byte is consumed in the cycle its strobe is high. All outputs are
// registered.
//
// Ports:
//   i_clk          receiver clock; everything in this block runs on it
//   i_reset        synchronous, active-high reset
//   i_data         received byte, looked at only while i_data_valid = 1
//   i_data_valid   one-cycle strobe per byte; may be high on back-to-back cycles
//   o_value        last committed value; holds between commits
//   o_value_valid  one-cycle pulse when o_value is updated
//   o_error        one-cycle pulse on a parse error, overflow or entry timeout
//   o_busy         high while the parser is not IDLE
//   o_digit_count  number of digits in the current partial entry
module uart_hex_cmd_parser #(
    parameter int N_DATA_BITS    = 8,
    parameter int DISPLAY_DIGITS = 4,
    parameter int TIMEOUT_CYCLES = 16000000
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [N_DATA_BITS-1:0]               i_data,
    input  logic                                 i_data_valid,
    output logic [4*DISPLAY_DIGITS-1:0]          o_value,
    output logic                                 o_value_valid,
    output logic                                 o_error,
    output logic                                 o_busy,
    output logic [$clog2(DISPLAY_DIGITS+1)-1:0]  o_digit_count
);

    localparam int VW = 4 * DISPLAY_DIGITS;
    localparam int CW = $clog2(DISPLAY_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [VW-1:0]   shift_reg, shift_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic [VW-1:0]   value_reg, value_next;
    logic            value_valid_reg, value_valid_next;
    logic            error_reg, error_next;

    logic            is_hex, is_term, is_bs, is_esc;
    logic [3:0]      nibble;
    logic            timeout_hit;

    // Byte classification. The full received word is compared, so any upper
    // bits beyond the ASCII range make the byte OTHER.
    always_comb begin
        is_hex  = 1'b0;
        is_term = 1'b0;
        is_bs   = 1'b0;
        is_esc  = 1'b0;
        nibble  = 4'h0;
        if (i_data >= N_DATA_BITS'('h30) && i_data <= N_DATA_BITS'('h39)) begin
            is_hex = 1'b1;
            nibble = 4'(i_data - N_DATA_BITS'('h30));
        end else if (i_data >= N_DATA_BITS'('h41) && i_data <= N_DATA_BITS'('h46)) begin
            is_hex = 1'b1;
            nibble = 4'(i_data - N_DATA_BITS'('h37));
        end else if (i_data >= N_DATA_BITS'('h61) && i_data <= N_DATA_BITS'('h66)) begin
            is_hex = 1'b1;
            nibble = 4'(i_data - N_DATA_BITS'('h57));
        end else if (i_data == N_DATA_BITS'('h0D) || i_data == N_DATA_BITS'('h0A)) begin
            is_term = 1'b1;
        end else if (i_data == N_DATA_BITS'('h08)) begin
            is_bs = 1'b1;
        end else if (i_data == N_DATA_BITS'('h1B)) begin
            is_esc = 1'b1;
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout_hit = !i_data_valid && (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        count_next       = count_reg;
        value_next       = value_reg;
        value_valid_next = 1'b0;
        error_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_data_valid) begin
                    if (is_hex) begin
                        shift_next = VW'(nibble);
                        count_next = CW'(1);
                        state_next = COLLECT;
                    end else if (!(is_term || is_bs || is_esc)) begin
                        // Stray TERM/BS/ESC in IDLE are ignored, so a CRLF
                        // pair yields a single commit.
                        error_next = 1'b1;
                        state_next = ERROR;
                    end
                end
            end

            COLLECT: begin
                if (i_data_valid) begin
                    if (is_hex) begin
                        if (count_reg == CW'(DISPLAY_DIGITS)) begin
                            error_next = 1'b1;
                            shift_next = '0;
                            count_next = '0;
                            state_next = ERROR;
                        end else begin
                            shift_next = (shift_reg << 4) | VW'(nibble);
                            count_next = count_reg + CW'(1);
                        end
                    end else if (is_term) begin
                        value_next       = shift_reg;
                        value_valid_next = 1'b1;
                        shift_next       = '0;
                        count_next       = '0;
                        state_next       = IDLE;
                    end else if (is_bs) begin
                        shift_next = shift_reg >> 4;
                        count_next = count_reg - CW'(1);
                        if (count_reg == CW'(1)) begin
                            state_next = IDLE;
                        end
                    end else if (is_esc) begin
                        shift_next = '0;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        error_next = 1'b1;
                        shift_next = '0;
                        count_next = '0;
                        state_next = ERROR;
                    end
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    shift_next = '0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end

            ERROR: begin
                if (i_data_valid) begin
                    if (is_term || is_esc) begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    // Leave silently: the error was already reported.
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                shift_next = '0;
                count_next = '0;
            end
        endcase

        // Idle-timeout counter.
        // - Restarts on every byte, while IDLE, and when it fires.
        // - Otherwise counts up, saturating at TIMEOUT_CYCLES.
        if (i_data_valid || state_reg == IDLE || timeout_hit) begin
            tcnt_next = '0;
        end else if (tcnt_reg != TW'(TIMEOUT_CYCLES)) begin
            tcnt_next = tcnt_reg + TW'(1);
        end else begin
            tcnt_next = tcnt_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            count_reg       <= '0;
            tcnt_reg        <= '0;
            value_reg       <= '0;
            value_valid_reg <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            count_reg       <= count_next;
            tcnt_reg        <= tcnt_next;
            value_reg       <= value_next;
            value_valid_reg <= value_valid_next;
            error_reg       <= error_next;
        end
    end

    assign o_value       = value_reg;
    assign o_value_valid = value_valid_reg;
    assign o_error       = error_reg;
    assign o_busy        = (state_reg != IDLE);
    assign o_digit_count = count_reg;

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Directed testbench for uart_hex_cmd_parser.
// The DUT is built with TIMEOUT_CYCLES = 20 so the idle timeout can be
// exercised in a short run.
module tb_uart_hex_cmd_parser;

    localparam int NDB = 8;
    localparam int DD  = 4;
    localparam int TO  = 20;

    logic           clk = 1'b0;
    logic           srst;
    logic [NDB-1:0] data;
    logic           data_valid;
    logic [4*DD-1:0] value;
    logic           value_valid;
    logic           error;
    logic           busy;
    logic [$clog2(DD+1)-1:0] digit_count;

    int checks   = 0;
    int failures = 0;
    int vv_pulses = 0;
    int er_pulses = 0;
    int base_vv, base_er;
    int hit_cycle;

    uart_hex_cmd_parser #(
        .N_DATA_BITS    (NDB),
        .DISPLAY_DIGITS (DD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (srst),
        .i_data        (data),
        .i_data_valid  (data_valid),
        .o_value       (value),
        .o_value_valid (value_valid),
        .o_error       (error),
        .o_busy        (busy),
        .o_digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (value_valid) vv_pulses++;
        if (error)       er_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present one byte for one cycle. Returns 1 time unit after the sampling
    // edge, so the registered results of this byte are already visible.
    task automatic send(input logic [7:0] b);
        data       = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        $display("tx byte=%02h value=%04h vv=%0d err=%0d busy=%0d cnt=%0d",
                 b, value, value_valid, error, busy, digit_count);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        srst       = 1'b1;
        data       = '0;
        data_valid = 1'b0;
        idle(3);
        check_eq("rst_value", 32'(value), 32'h0);
        check_eq("rst_vv",    32'(value_valid), 32'h0);
        check_eq("rst_err",   32'(error), 32'h0);
        check_eq("rst_busy",  32'(busy), 32'h0);
        check_eq("rst_count", 32'(digit_count), 32'h0);
        srst = 1'b0;
        idle(1);

        // 1: "1A3F" CR, bytes two cycles apart.
        base_vv = vv_pulses;
        send(8'h31); check_eq("t1_cnt1", 32'(digit_count), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        idle(1);
        send(8'h41); idle(1);
        send(8'h33); idle(1);
        send(8'h46); check_eq("t1_cnt4", 32'(digit_count), 32'd4);
        idle(1);
        send(8'h0D);
        check_eq("t1_value", 32'(value), 32'h1A3F);
        check_eq("t1_vv",    32'(value_valid), 32'd1);
        check_eq("t1_busy0", 32'(busy), 32'd0);
        idle(1);
        check_eq("t1_vv_low", 32'(value_valid), 32'd0);
        check_eq("t1_pulses", 32'(vv_pulses - base_vv), 32'd1);

        // 2: "7" CR LF -> single commit.
        base_vv = vv_pulses;
        base_er = er_pulses;
        send(8'h37); send(8'h0D); send(8'h0A);
        idle(2);
        check_eq("t2_value",  32'(value), 32'h0007);
        check_eq("t2_pulses", 32'(vv_pulses - base_vv), 32'd1);
        check_eq("t2_err",    32'(er_pulses - base_er), 32'd0);

        // 3: overflow on the fifth digit.
        base_vv = vv_pulses;
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        check_eq("t3_cnt4", 32'(digit_count), 32'd4);
        send(8'h35);
        check_eq("t3_err",  32'(error), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd1);
        check_eq("t3_cnt0", 32'(digit_count), 32'd0);
        idle(1);
        send(8'h0D);
        check_eq("t3_busy0", 32'(busy), 32'd0);
        check_eq("t3_value", 32'(value), 32'h0007);
        check_eq("t3_nocommit", 32'(vv_pulses - base_vv), 32'd0);

        // 4: "AB" BS "c" CR -> 0x00AC.
        send(8'h41); check_eq("t4_c1", 32'(digit_count), 32'd1);
        send(8'h42); check_eq("t4_c2", 32'(digit_count), 32'd2);
        send(8'h08); check_eq("t4_c3", 32'(digit_count), 32'd1);
        send(8'h63); check_eq("t4_c4", 32'(digit_count), 32'd2);
        send(8'h0D);
        check_eq("t4_value", 32'(value), 32'h00AC);

        // 5a: "9" then idle -> error exactly TO cycles after the sample edge.
        base_er = er_pulses;
        send(8'h39);
        hit_cycle = 0;
        for (int k = 1; k <= TO + 10; k++) begin
            @(posedge clk);
            #1;
            if (error) begin
                hit_cycle = k;
                break;
            end
        end
        check_eq("t5_hit_cycle", 32'(hit_cycle), 32'(TO));
        check_eq("t5_busy",  32'(busy), 32'd0);
        check_eq("t5_value", 32'(value), 32'h00AC);
        check_eq("t5_cnt",   32'(digit_count), 32'd0);
        idle(5);
        check_eq("t5_one_err", 32'(er_pulses - base_er), 32'd1);

        // 5b: byte arriving on the expiry cycle suppresses the timeout.
        base_er = er_pulses;
        send(8'h39);
        idle(TO - 1);
        send(8'h41);
        check_eq("t5b_err",  32'(error), 32'd0);
        check_eq("t5b_cnt",  32'(digit_count), 32'd2);
        check_eq("t5b_busy", 32'(busy), 32'd1);
        send(8'h1B);
        check_eq("t5b_noerr", 32'(er_pulses - base_er), 32'd0);

        // 5c: timeout out of ERROR is silent.
        base_er = er_pulses;
        send(8'h5A);
        check_eq("t5c_err", 32'(error), 32'd1);
        idle(TO + 5);
        check_eq("t5c_busy", 32'(busy), 32'd0);
        check_eq("t5c_one_err", 32'(er_pulses - base_er), 32'd1);

        // 6: "5G" ESC "E" CR back-to-back.
        send(8'h35);
        send(8'h47);
        check_eq("t6_err_g", 32'(error), 32'd1);
        send(8'h1B);
        check_eq("t6_err_esc", 32'(error), 32'd0);
        check_eq("t6_busy_esc", 32'(busy), 32'd0);
        send(8'h45);
        send(8'h0D);
        check_eq("t6_value", 32'(value), 32'h000E);
        check_eq("t6_vv", 32'(value_valid), 32'd1);

        // Reset arriving together with a digit of a new entry.
        send(8'h31);
        data       = 8'h33;
        data_valid = 1'b1;
        srst       = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        srst       = 1'b0;
        check_eq("t6_rst_value", 32'(value), 32'h0);
        check_eq("t6_rst_busy",  32'(busy), 32'd0);
        check_eq("t6_rst_cnt",   32'(digit_count), 32'd0);
        check_eq("t6_rst_err",   32'(error), 32'd0);
        check_eq("t6_rst_vv",    32'(value_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
